// File: rtl/axis_stream_processor.sv
//==============================================================================
// Module   : axis_stream_processor
// Brief    : AXI-Stream command front end that feeds spikes to a network core,
//            steps it for commanded run lengths and returns one beat per step.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module axis_stream_processor #(
    parameter int TDATA_WIDTH = 32,
    parameter int OPC_WIDTH   = 2,
    parameter int INP_WIDTH   = 8,
    parameter int OUT_WIDTH   = 8,
    parameter int RUN_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [TDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [INP_WIDTH-1:0]   net_inp,
    output logic                   net_en,
    output logic                   net_arst,
    input  logic [OUT_WIDTH-1:0]   net_out,
    output logic                   busy
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_CLR  = 2'd2;

    localparam logic [OPC_WIDTH-1:0] c_OPC_SPK = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] c_OPC_RUN = OPC_WIDTH'(2);
    localparam logic [OPC_WIDTH-1:0] c_OPC_CLR = OPC_WIDTH'(3);

    localparam logic [c_AW:0]        c_FIFO_FULL = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]        c_CNT_ONE   = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]      c_PTR_ONE   = c_AW'(1);
    localparam logic [RUN_WIDTH-1:0] c_RUN_ONE   = RUN_WIDTH'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [INP_WIDTH-1:0] r_pend;
    logic [RUN_WIDTH-1:0] r_cnt;
    logic                 r_first;

    logic [OUT_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic                 r_mem_last [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_count;

    logic [OPC_WIDTH-1:0] w_opc;
    logic [INP_WIDTH-1:0] w_spk_payload;
    logic [RUN_WIDTH-1:0] w_run_len;
    logic                 w_cmd_hs;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_step;
    logic                 w_pop;
    logic                 w_last_step;
    logic                 w_unused_tdata;

    assign w_opc          = s_tdata[TDATA_WIDTH-1 -: OPC_WIDTH];
    assign w_spk_payload  = s_tdata[INP_WIDTH-1:0];
    assign w_run_len      = s_tdata[RUN_WIDTH-1:0];
    assign w_unused_tdata = ^s_tdata;
    assign w_cmd_hs       = s_tvalid && s_tready;

    assign w_full      = (r_count == c_FIFO_FULL);
    assign w_empty     = (r_count == '0);
    assign w_pop       = !w_empty && m_tready;
    assign w_last_step = (r_cnt == c_RUN_ONE);

    //--------------------------------------------------------------------------
    // Control FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_cmd_hs) begin
                    if ((w_opc == c_OPC_RUN) && (w_run_len != '0)) begin
                        w_state_nxt = c_S_RUN;
                    end else if (w_opc == c_OPC_CLR) begin
                        w_state_nxt = c_S_CLR;
                    end
                end
            end
            c_S_RUN: begin
                if (w_step && w_last_step) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_CLR: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // A full FIFO stalls the network; a pop in the same cycle does not unblock it.
    always_comb begin
        s_tready = (r_state == c_S_IDLE);
        w_step   = 1'b0;
        net_arst = 1'b0;
        net_inp  = '0;
        case (r_state)
            c_S_RUN: w_step   = !w_full;
            c_S_CLR: net_arst = 1'b1;
            default: ;
        endcase
        if (w_step && r_first) begin
            net_inp = r_pend;
        end
    end

    assign net_en = w_step;
    assign busy   = (r_state != c_S_IDLE) || !w_empty;

    //--------------------------------------------------------------------------
    // Pending spikes and run counter
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_pend  <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
        end else begin
            if (w_cmd_hs && (w_opc == c_OPC_SPK)) begin
                r_pend <= r_pend | w_spk_payload;
            end else if (r_state == c_S_CLR) begin
                r_pend <= '0;
            end else if (w_step && r_first) begin
                r_pend <= '0;
            end

            if (w_cmd_hs && (w_opc == c_OPC_RUN) && (w_run_len != '0)) begin
                r_cnt   <= w_run_len;
                r_first <= 1'b1;
            end else if (w_step) begin
                r_cnt   <= r_cnt - c_RUN_ONE;
                r_first <= 1'b0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Output FIFO
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_step) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_step, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the read side is masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_step) begin
            r_mem_data[r_wr_ptr] <= net_out;
            r_mem_last[r_wr_ptr] <= w_last_step;
        end
    end

    assign m_tvalid = !w_empty;
    assign m_tdata  = m_tvalid ? TDATA_WIDTH'(r_mem_data[r_rd_ptr]) : '0;
    assign m_tlast  = m_tvalid && r_mem_last[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_axis_stream_processor.sv
//==============================================================================
// Module   : tb_axis_stream_processor
// Brief    : Self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_stream_processor;

    localparam int TW    = 32;
    localparam int OPW   = 2;
    localparam int IW    = 8;
    localparam int OW    = 8;
    localparam int RW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [TW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [TW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [IW-1:0] net_inp;
    logic          net_en;
    logic          net_arst;
    logic [OW-1:0] net_out;
    logic          busy;

    logic [OW-1:0] noise = '0;
    int            rdy_mode = 1;
    bit            noise_en = 1'b0;

    // Network stand-in: echoes its input, optionally scrambled.
    assign net_out = net_inp ^ noise;

    axis_stream_processor #(
        .TDATA_WIDTH(TW), .OPC_WIDTH(OPW), .INP_WIDTH(IW),
        .OUT_WIDTH(OW), .RUN_WIDTH(RW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst(arst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .net_inp(net_inp), .net_en(net_en), .net_arst(net_arst), .net_out(net_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    int            m_mode = 0;          // 0 idle, 1 running, 2 clearing
    logic [IW-1:0] m_pend = '0;
    int            m_rem = 0;
    bit            m_first = 1'b0;
    logic [OW-1:0] m_qd[$];
    bit            m_ql[$];

    // Observation counters, written only by the monitor
    int            en_total = 0;
    int            nrdy_total = 0;
    int            arst_total = 0;
    int            hs_cyc_mon = 0;
    int            first_en_cyc = 0;
    int            en_since_hs = 0;
    logic [32:0]   obs[$];

    initial begin : monitor
        bit            exp_en;
        logic [IW-1:0] exp_inp;
        logic [OW-1:0] exp_data;
        bit            exp_last;
        bit            exp_val;
        int            opc;
        int            n;
        forever begin
            @(negedge clk);
            cyc++;
            if (arst) begin
                m_mode = 0; m_pend = '0; m_rem = 0; m_first = 1'b0;
                m_qd.delete(); m_ql.delete();
            end else begin
                exp_en   = (m_mode == 1) && (m_qd.size() < DEPTH);
                exp_inp  = (exp_en && m_first) ? m_pend : '0;
                exp_val  = (m_qd.size() > 0);
                exp_data = exp_val ? m_qd[0] : '0;
                exp_last = exp_val ? m_ql[0] : 1'b0;

                check("s_tready", s_tready, m_mode == 0);
                check("net_en",   net_en,   exp_en);
                check("net_arst", net_arst, m_mode == 2);
                check("net_inp",  net_inp,  exp_inp);
                check("m_tvalid", m_tvalid, exp_val);
                check("m_tdata",  m_tdata,  {24'h0, exp_data});
                check("m_tlast",  m_tlast,  exp_last);
                check("busy",     busy,     (m_mode != 0) || exp_val);

                if (s_tvalid && s_tready) begin
                    hs_cyc_mon  = cyc;
                    en_since_hs = 0;
                end
                if (net_en) begin
                    if (en_since_hs == 0) first_en_cyc = cyc;
                    en_since_hs++;
                    en_total++;
                end
                if (!s_tready) nrdy_total++;
                if (net_arst) arst_total++;
                if (m_tvalid && m_tready) obs.push_back({m_tlast, m_tdata});

                if (exp_val && m_tready) begin
                    void'(m_qd.pop_front());
                    void'(m_ql.pop_front());
                end
                if (exp_en) begin
                    m_qd.push_back(exp_inp ^ noise);
                    m_ql.push_back(m_rem == 1);
                    m_rem--;
                    if (m_first) begin
                        m_first = 1'b0;
                        m_pend  = '0;
                    end
                    if (m_rem == 0) m_mode = 0;
                end else if (m_mode == 2) begin
                    m_pend = '0;
                    m_mode = 0;
                end else if ((m_mode == 0) && s_tvalid) begin
                    opc = int'(s_tdata[TW-1 -: OPW]);
                    n   = int'(s_tdata[RW-1:0]);
                    case (opc)
                        1: m_pend = m_pend | s_tdata[IW-1:0];
                        2: if (n > 0) begin m_mode = 1; m_rem = n; m_first = 1'b1; end
                        3: m_mode = 2;
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin : sink_driver
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = ($urandom_range(0, 2) != 0);
            endcase
            noise = noise_en ? OW'($urandom) : '0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] opc, input logic [29:0] pay);
        bit got;
        got = 1'b0;
        s_tdata  = {opc, pay};
        s_tvalid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = s_tready;
            @(posedge clk);
            #1;
        end
        if (!got) check("send_timeout", 0, 1);
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            done = !busy;
        end
        if (!done) check("idle_timeout", 0, 1);
        tick(1);
    endtask

    int b0, e0, r0, a0;

    initial begin : main
        #3;
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata",  m_tdata,  0);
        check("rst_net_en",   net_en,   0);
        check("rst_busy",     busy,     0);
        tick(3);
        arst = 1'b0;
        tick(1);
        check("post_rst_s_tready", s_tready, 1);

        // Normal run
        rdy_mode = 1;
        b0 = obs.size(); e0 = en_total; r0 = nrdy_total;
        send(2'd1, 30'h05);
        send(2'd1, 30'h30);
        send(2'd2, 30'd3);
        wait_idle();
        check("run3_steps",     en_total - e0, 3);
        check("run3_nrdy",      nrdy_total - r0, 3);
        check("run3_latency",   first_en_cyc - hs_cyc_mon, 1);
        check("run3_beats",     obs.size() - b0, 3);
        if (obs.size() - b0 == 3) begin
            check("run3_beat0", obs[b0],   {1'b0, 32'h35});
            check("run3_beat1", obs[b0+1], {1'b0, 32'h00});
            check("run3_beat2", obs[b0+2], {1'b1, 32'h00});
        end

        // Zero-length run keeps pending spikes
        b0 = obs.size(); e0 = en_total;
        send(2'd1, 30'h0F);
        send(2'd2, 30'd0);
        tick(5);
        check("run0_steps",    en_total - e0, 0);
        check("run0_beats",    obs.size() - b0, 0);
        check("run0_s_tready", s_tready, 1);
        send(2'd2, 30'd1);
        wait_idle();
        check("run1_beats", obs.size() - b0, 1);
        if (obs.size() - b0 == 1) check("run1_beat", obs[b0], {1'b1, 32'h0F});

        // Clear
        a0 = arst_total; e0 = en_total;
        send(2'd1, 30'hAA);
        send(2'd3, 30'd0);
        wait_idle();
        check("clr_pulses", arst_total - a0, 1);
        check("clr_steps",  en_total - e0, 0);
        b0 = obs.size();
        send(2'd2, 30'd1);
        wait_idle();
        check("clr_run_beats", obs.size() - b0, 1);
        if (obs.size() - b0 == 1) check("clr_run_beat", obs[b0], {1'b1, 32'h00});

        // Backpressure
        send(2'd1, 30'h11);
        rdy_mode = 0;
        tick(1);
        b0 = obs.size(); e0 = en_total;
        send(2'd2, 30'd10);
        tick(20);
        check("bp_steps",    en_total - e0, 4);
        check("bp_s_tready", s_tready, 0);
        check("bp_busy",     busy, 1);
        check("bp_beats",    obs.size() - b0, 0);
        rdy_mode = 1;
        wait_idle();
        check("bp_total_beats", obs.size() - b0, 10);
        if (obs.size() - b0 == 10) begin
            for (int i = 0; i < 10; i++) begin
                check("bp_beat", obs[b0+i], {(i == 9), (i == 0) ? 32'h11 : 32'h00});
            end
        end
        check("bp_busy_end", busy, 0);

        // Reset mid-run
        rdy_mode = 0;
        tick(1);
        e0 = en_total;
        send(2'd2, 30'd8);
        for (int i = 0; i < 50 && (en_total - e0) < 2; i++) @(negedge clk);
        @(posedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("mid_rst_m_tvalid", m_tvalid, 0);
        check("mid_rst_busy",     busy, 0);
        check("mid_rst_s_tready", s_tready, 1);
        check("mid_rst_net_en",   net_en, 0);
        check("mid_rst_m_tlast",  m_tlast, 0);
        tick(2);
        arst = 1'b0;
        rdy_mode = 1;
        tick(1);
        b0 = obs.size(); e0 = en_total;
        send(2'd2, 30'd1);
        wait_idle();
        check("post_rst_beats", obs.size() - b0, 1);
        check("post_rst_steps", en_total - e0, 1);

        // Randomized traffic against the model
        rdy_mode = 2;
        noise_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3)      send(2'd1, 30'($urandom));
            else if (r <= 6) send(2'd2, {14'($urandom), 16'($urandom_range(0, 6))});
            else if (r == 7) send(2'd3, 30'($urandom));
            else if (r == 8) send(2'd0, 30'($urandom));
            else             tick($urandom_range(0, 3));
        end
        rdy_mode = 1;
        wait_idle();
        noise_en = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
